// File: rtl/vec_unit_ctrl.sv
// Initiator-side controller for the VecUnit datapath: owns the vector register
// file, sequences accept -> execute -> writeback and counts completed instructions.

package vec_unit_pkg;
    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        DOT   = 2'd2,
        SCALE = 2'd3
    } vec_unit_op_t;
endpackage

module vec_unit_ctrl
    import vec_unit_pkg::*;
#(
    parameter  int WIDTH  = 128,
    parameter  int NREGS  = 8,
    parameter  int CNT_W  = 32,
    parameter  int DATA_W = 32,
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  vec_unit_op_t             instr_op,
    input  logic [AW-1:0]            instr_dst,
    input  logic [AW-1:0]            instr_src1,
    input  logic [AW-1:0]            instr_src2,
    input  logic signed [DATA_W-1:0] instr_k,

    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_addr,
    input  logic signed [DATA_W-1:0] ld_data [WIDTH],

    input  logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] rd_data [WIDTH],

    output vec_unit_op_t             vu_op,
    output logic signed [DATA_W-1:0] vu_k,
    output logic signed [DATA_W-1:0] vu_in1 [WIDTH],
    output logic signed [DATA_W-1:0] vu_in2 [WIDTH],
    input  logic signed [DATA_W-1:0] vu_out [WIDTH],

    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_W-1:0] regs  [NREGS][WIDTH];
    logic signed [DATA_W-1:0] res_q [WIDTH];
    logic [AW-1:0]            dst_q;

    logic instr_accept;
    logic ld_accept;

    // Handshakes are held low while reset is asserted; a pending load wins over an instruction.
    assign ld_ready     = reset_n && (state == IDLE);
    assign instr_ready  = reset_n && (state == IDLE) && !ld_valid;
    assign instr_accept = instr_valid && instr_ready;
    assign ld_accept    = ld_valid && ld_ready;

    assign busy = (state != IDLE);
    assign done = (state == WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accept edge: operands are captured here so a WB to a source register cannot disturb them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vu_op <= ADD;
            vu_k  <= '0;
            dst_q <= '0;
            for (int l = 0; l < WIDTH; l++) begin
                vu_in1[l] <= '0;
                vu_in2[l] <= '0;
            end
        end else if (instr_accept) begin
            vu_op  <= instr_op;
            vu_k   <= instr_k;
            dst_q  <= instr_dst;
            vu_in1 <= regs[instr_src1];
            vu_in2 <= regs[instr_src2];
        end
    end

    // End of EXEC: sample the combinational VecUnit result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < WIDTH; l++) begin
                res_q[l] <= '0;
            end
        end else if (state == EXEC) begin
            res_q <= vu_out;
        end
    end

    // Register file: loads only in IDLE and writebacks only in WB, so the two never collide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                for (int l = 0; l < WIDTH; l++) begin
                    regs[r][l] <= '0;
                end
            end
        end else begin
            if (ld_accept) begin
                regs[ld_addr] <= ld_data;
            end
            if (state == WB) begin
                regs[dst_q] <= res_q;
            end
        end
    end

    // Readback is a plain registered read; a same-edge write is not forwarded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < WIDTH; l++) begin
                rd_data[l] <= '0;
            end
        end else begin
            rd_data <= regs[rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= '0;
        end else if (state == WB) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vec_unit_ctrl.sv
// Scoreboard bench for vec_unit_ctrl with a behavioural VecUnit (Q16.16 lanes)
// attached to the vu_* ports.

module tb_vec_unit_ctrl;
    import vec_unit_pkg::*;

    localparam int WIDTH  = 8;
    localparam int NREGS  = 8;
    localparam int CNT_W  = 4;
    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int AW     = 3;
    localparam int PW     = WIDTH * DATA_W;

    typedef logic [PW-1:0] pvec_t;

    localparam logic [31:0] FX_0_5  = 32'h0000_8000;
    localparam logic [31:0] FX_1_0  = 32'h0001_0000;
    localparam logic [31:0] FX_2_0  = 32'h0002_0000;
    localparam logic [31:0] FX_2_5  = 32'h0002_8000;
    localparam logic [31:0] FX_4_0  = 32'h0004_0000;
    localparam logic [31:0] FX_4_5  = 32'h0004_8000;
    localparam logic [31:0] FX_M1_5 = 32'hFFFE_8000;
    localparam logic [31:0] FX_M3_0 = 32'hFFFD_0000;
    localparam logic [31:0] FX_M6_0 = 32'hFFFA_0000;

    logic                     clock;
    logic                     reset_n;
    logic                     instr_valid;
    logic                     instr_ready;
    vec_unit_op_t             instr_op;
    logic [AW-1:0]            instr_dst;
    logic [AW-1:0]            instr_src1;
    logic [AW-1:0]            instr_src2;
    logic signed [DATA_W-1:0] instr_k;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [AW-1:0]            ld_addr;
    logic signed [DATA_W-1:0] ld_data [WIDTH];
    logic [AW-1:0]            rd_addr;
    logic signed [DATA_W-1:0] rd_data [WIDTH];
    vec_unit_op_t             vu_op;
    logic signed [DATA_W-1:0] vu_k;
    logic signed [DATA_W-1:0] vu_in1 [WIDTH];
    logic signed [DATA_W-1:0] vu_in2 [WIDTH];
    logic signed [DATA_W-1:0] vu_out [WIDTH];
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         op_count;

    pvec_t          ld_vec;
    logic [AW-1:0]  stim_addr;
    logic [AW-1:0]  mon_addr;
    logic           mon_active;

    pvec_t          mreg [NREGS];
    logic [CNT_W-1:0] m_count;
    int             sb_dst [$];
    pvec_t          sb_old [$];
    pvec_t          sb_new [$];

    int n_checks;
    int n_errors;

    vec_unit_ctrl #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_src1  (instr_src1),
        .instr_src2  (instr_src2),
        .instr_k     (instr_k),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .vu_op       (vu_op),
        .vu_k        (vu_k),
        .vu_in1      (vu_in1),
        .vu_in2      (vu_in2),
        .vu_out      (vu_out),
        .busy        (busy),
        .done        (done),
        .op_count    (op_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural VecUnit: lane-wise ops on signed Q16.16 values.
    function automatic logic [DATA_W-1:0] vu_lane(input vec_unit_op_t op,
                                                  input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b,
                                                  input logic signed [DATA_W-1:0] k);
        logic signed [2*DATA_W-1:0] p;
        p = '0;
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            DOT:     p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            default: p = (2*DATA_W)'(a) * (2*DATA_W)'(k);
        endcase
        return p[FRAC_W +: DATA_W];
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            vu_out[i] = vu_lane(vu_op, vu_in1[i], vu_in2[i], vu_k);
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ld_data[i] = ld_vec[i*DATA_W +: DATA_W];
        end
    end

    assign rd_addr = mon_active ? mon_addr : stim_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pvec_t splat(input logic [31:0] v);
        pvec_t r;
        for (int i = 0; i < WIDTH; i++) r[i*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_push(input vec_unit_op_t op, input logic [AW-1:0] dst,
                           input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [31:0] k);
        pvec_t r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i*DATA_W +: DATA_W] = vu_lane(op, mreg[s1][i*DATA_W +: DATA_W],
                                            mreg[s2][i*DATA_W +: DATA_W], k);
        end
        sb_dst.push_back(int'(dst));
        sb_old.push_back(mreg[dst]);
        sb_new.push_back(r);
        mreg[dst] = r;
        m_count   = m_count + CNT_W'(1);
    endtask

    // Output side of the scoreboard: on each done pulse, read the destination back
    // across the WB edge (old value) and the following edge (written value).
    initial begin : monitor
        int    d;
        pvec_t e_old;
        pvec_t e_new;
        mon_active = 1'b0;
        mon_addr   = '0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                chk("sb_pending", 32'(sb_dst.size() != 0), 32'd1);
                if (sb_dst.size() != 0) begin
                    d     = sb_dst.pop_front();
                    e_old = sb_old.pop_front();
                    e_new = sb_new.pop_front();
                    mon_addr   = AW'(d);
                    mon_active = 1'b1;
                    @(posedge clock); #1;
                    for (int i = 0; i < WIDTH; i++)
                        chk("rd_during_wb_old", rd_data[i], e_old[i*DATA_W +: DATA_W]);
                    @(posedge clock); #1;
                    for (int i = 0; i < WIDTH; i++)
                        chk("wb_result", rd_data[i], e_new[i*DATA_W +: DATA_W]);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic do_load(input logic [AW-1:0] addr, input pvec_t v);
        int n;
        ld_addr  = addr;
        ld_vec   = v;
        ld_valid = 1'b1;
        #1;
        n = 0;
        while (!ld_ready && n < 20) begin tick(); n++; end
        chk("ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid   = 1'b0;
        mreg[addr] = v;
    endtask

    task automatic send_instr(input vec_unit_op_t op, input logic [AW-1:0] dst,
                              input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                              input logic [31:0] k, input bit push);
        int n;
        instr_op    = op;
        instr_dst   = dst;
        instr_src1  = s1;
        instr_src2  = s2;
        instr_k     = k;
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin tick(); n++; end
        chk("instr_ready", 32'(instr_ready), 32'd1);
        if (push) sb_push(op, dst, s1, s2, k);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic run_instr(input vec_unit_op_t op, input logic [AW-1:0] dst,
                             input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                             input logic [31:0] k);
        send_instr(op, dst, s1, s2, k, 1'b1);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_done", 32'(done), 32'd0);
        chk("exec_ready", 32'(instr_ready), 32'd0);
        chk("exec_vu_op", 32'(vu_op), 32'(op));
        tick();
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_busy", 32'(busy), 32'd1);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("op_count", 32'(op_count), 32'(m_count));
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr, input pvec_t exp);
        int n;
        n = 0;
        while (mon_active && n < 10) begin tick(); n++; end
        stim_addr = addr;
        tick();
        for (int i = 0; i < WIDTH; i++) chk(tag, rd_data[i], exp[i*DATA_W +: DATA_W]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        pvec_t garbage;
        pvec_t lanes;
        pvec_t lanes2;
        int    acc1;
        int    acc2;
        logic  rdy;
        logic [31:0] kr;

        n_checks    = 0;
        n_errors    = 0;
        m_count     = '0;
        reset_n     = 1'b1;
        instr_valid = 1'b0;
        instr_op    = ADD;
        instr_dst   = '0;
        instr_src1  = '0;
        instr_src2  = '0;
        instr_k     = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_vec      = '0;
        stim_addr   = '0;
        for (int r = 0; r < NREGS; r++) mreg[r] = '0;

        // Reset state, with both valids offered.
        #1 reset_n  = 1'b0;
        instr_valid = 1'b1;
        ld_valid    = 1'b1;
        #3;
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_vu_op", 32'(vu_op), 32'(ADD));
        chk("rst_vu_k", vu_k, 32'd0);
        chk("rst_vu_in1", vu_in1[0], 32'd0);
        chk("rst_rd_data", rd_data[WIDTH-1], 32'd0);
        instr_valid = 1'b0;
        ld_valid    = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("idle_ld_ready", 32'(ld_ready), 32'd1);
        chk("idle_instr_ready", 32'(instr_ready), 32'd1);
        tick();

        // T1: ADD
        do_load(3'd1, splat(FX_2_0));
        do_load(3'd2, splat(FX_0_5));
        run_instr(ADD, 3'd3, 3'd1, 3'd2, 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);
        read_check("t1_r3", 3'd3, splat(FX_2_5));

        // T2: SCALE ignores src2, then SUB
        for (int i = 0; i < WIDTH; i++) garbage[i*DATA_W +: DATA_W] = $urandom;
        do_load(3'd2, garbage);
        run_instr(SCALE, 3'd4, 3'd1, 3'd2, FX_M3_0);
        read_check("t2_r4", 3'd4, splat(FX_M6_0));
        do_load(3'd2, splat(FX_0_5));
        run_instr(SUB, 3'd5, 3'd2, 3'd1, 32'd0);
        read_check("t2_r5", 3'd5, splat(FX_M1_5));

        // T3: DOT with dst==src, then a second instruction with valid held
        instr_op    = DOT;
        instr_dst   = 3'd1;
        instr_src1  = 3'd1;
        instr_src2  = 3'd1;
        instr_k     = '0;
        instr_valid = 1'b1;
        acc1 = -1;
        acc2 = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            rdy = instr_ready;
            if (rdy) begin
                if (acc1 < 0) begin
                    acc1 = c;
                    sb_push(DOT, 3'd1, 3'd1, 3'd1, 32'd0);
                end else begin
                    acc2 = c;
                    sb_push(ADD, 3'd6, 3'd1, 3'd2, 32'd0);
                end
            end else begin
                chk("t3_busy_while_blocked", 32'(busy), 32'd1);
            end
            tick();
            if (acc2 >= 0) begin
                instr_valid = 1'b0;
                break;
            end
            if (rdy) begin
                instr_op   = ADD;
                instr_dst  = 3'd6;
                instr_src1 = 3'd1;
                instr_src2 = 3'd2;
            end
        end
        instr_valid = 1'b0;
        chk("t3_accept_gap", 32'(acc2 - acc1), 32'd3);
        tick();
        tick();
        chk("t3_op_count", 32'(op_count), 32'(m_count));
        read_check("t3_r1", 3'd1, splat(FX_4_0));
        read_check("t3_r6", 3'd6, splat(FX_4_5));

        // T4: load wins over a same-cycle instruction, which then sees the new data
        instr_op    = ADD;
        instr_dst   = 3'd7;
        instr_src1  = 3'd6;
        instr_src2  = 3'd6;
        instr_k     = '0;
        instr_valid = 1'b1;
        ld_addr     = 3'd6;
        ld_vec      = splat(FX_1_0);
        ld_valid    = 1'b1;
        #1;
        chk("t4_instr_ready_blocked", 32'(instr_ready), 32'd0);
        chk("t4_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        mreg[6]  = splat(FX_1_0);
        run_instr(ADD, 3'd7, 3'd6, 3'd6, 32'd0);
        read_check("t4_r7", 3'd7, splat(FX_2_0));

        // T5: reset during EXEC aborts the instruction
        send_instr(ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0);
        chk("t5_exec_busy", 32'(busy), 32'd1);
        reset_n     = 1'b0;
        instr_valid = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_op_count", 32'(op_count), 32'd0);
        chk("t5_instr_ready", 32'(instr_ready), 32'd0);
        chk("t5_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        tick();
        chk("t5_done_held", 32'(done), 32'd0);
        instr_valid = 1'b0;
        reset_n     = 1'b1;
        for (int r = 0; r < NREGS; r++) mreg[r] = '0;
        m_count = '0;
        tick();
        read_check("t5_r3", 3'd3, '0);
        read_check("t5_r1", 3'd1, '0);

        // T6: lane ordering, then counter wrap over 17 instructions
        for (int i = 0; i < WIDTH; i++) begin
            lanes[i*DATA_W +: DATA_W]  = 32'(i) << FRAC_W;
            lanes2[i*DATA_W +: DATA_W] = 32'(2 * i) << FRAC_W;
        end
        do_load(3'd1, lanes);
        do_load(3'd2, lanes);
        run_instr(ADD, 3'd3, 3'd1, 3'd2, 32'd0);
        read_check("t6_lanes", 3'd3, lanes2);
        for (int j = 0; j < 16; j++) begin
            kr = 32'($urandom_range(0, 8 << FRAC_W)) - (32'd4 << FRAC_W);
            run_instr(vec_unit_op_t'($urandom_range(0, 3)), AW'($urandom_range(0, NREGS-1)),
                      AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)), kr);
        end
        chk("t6_wrap", 32'(op_count), 32'd1);

        tick();
        tick();
        tick();
        chk("sb_drain", 32'(sb_dst.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
